// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/result bundle between the lanes, the shared shifter arbiter and the result consumer.
interface shift_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH_IN = 8,
  parameter int SHIFT_AMOUNT  = 16
);
  localparam int SHIFT_BITS     = $clog2(SHIFT_AMOUNT);
  localparam int ID_BITS        = $clog2(NUM_REQ);
  localparam int DATA_WIDTH_OUT = SHIFT_AMOUNT + DATA_WIDTH_IN;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*DATA_WIDTH_IN-1:0] req_data;
  logic [NUM_REQ*SHIFT_BITS-1:0]    req_amount;
  logic [NUM_REQ-1:0]               req_dir;
  logic                             res_valid;
  logic                             res_ready;
  logic [DATA_WIDTH_OUT-1:0]        res_data;
  logic [ID_BITS-1:0]               res_id;
  modport master (
    output req_valid, req_data, req_amount, req_dir, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );
  modport slave (
    input  req_valid, req_data, req_amount, req_dir, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one sign-extending shifter, with a registered, backpressured result stage.
module shift_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH_IN = 8,
  parameter int SHIFT_AMOUNT  = 16
) (
  input logic           clk,
  input logic           rst,
  shift_arbiter_if.slave bus
);
  localparam int SHIFT_BITS     = $clog2(SHIFT_AMOUNT);
  localparam int ID_BITS        = $clog2(NUM_REQ);
  localparam int DATA_WIDTH_OUT = SHIFT_AMOUNT + DATA_WIDTH_IN;
  logic [ID_BITS-1:0]               ptr, off, gnt, ptr_next;
  logic [ID_BITS:0]                 sum;
  logic [2*NUM_REQ-1:0]             dbl;
  logic                             found, accept, dir;
  logic [DATA_WIDTH_IN-1:0]         opd;
  logic [SHIFT_BITS-1:0]            amt;
  logic signed [DATA_WIDTH_OUT-1:0] ext, shifted;
  // Rotate valids so bit 0 is the ptr position; the lowest set bit is the winner's offset.
  always_comb begin
    dbl = {bus.req_valid, bus.req_valid} >> ptr;
    off = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (dbl[i]) begin
        off = ID_BITS'(i);
        found = 1'b1;
      end
    sum = {1'b0, ptr} + {1'b0, off};
    gnt = sum >= (ID_BITS+1)'(NUM_REQ) ? ID_BITS'(sum - (ID_BITS+1)'(NUM_REQ)) : sum[ID_BITS-1:0];
    ptr_next = gnt == ID_BITS'(NUM_REQ - 1) ? '0 : gnt + 1'b1;
    accept = found && (!bus.res_valid || bus.res_ready) && !rst;
    bus.req_ready = accept ? NUM_REQ'(1) << gnt : '0;
    opd = bus.req_data[gnt*DATA_WIDTH_IN +: DATA_WIDTH_IN];
    amt = bus.req_amount[gnt*SHIFT_BITS +: SHIFT_BITS];
    dir = bus.req_dir[gnt];
    ext = {{SHIFT_AMOUNT{opd[DATA_WIDTH_IN-1]}}, opd};
    shifted = dir ? ext << amt : ext >>> amt;
  end
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
      bus.res_id <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
      bus.res_valid <= 1'b1;
      bus.res_data <= shifted;
      bus.res_id <= gnt;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed literal checks plus randomized traffic against a behavioural arbiter/shifter model.
module tb_shift_arbiter;
  localparam int N  = 4;
  localparam int DI = 8;
  localparam int SA = 16;
  localparam int SB = 4;
  localparam int DO = 24;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   check_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   m_ptr, m_rid;
  bit   m_rv;
  logic [DO-1:0] m_rd;
  shift_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH_IN(DI), .SHIFT_AMOUNT(SA)) bus ();
  shift_arbiter #(.NUM_REQ(N), .DATA_WIDTH_IN(DI), .SHIFT_AMOUNT(SA)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DO-1:0] shf(input logic [DI-1:0] d, input int amt, input bit dir);
    longint v = longint'($signed(d));
    return dir ? DO'(v << amt) : DO'(v >>> amt);
  endfunction

  function automatic int exp_grant();
    for (int k = 0; k < N; k++)
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g = exp_grant();
    if (rst || (m_rv && !bus.res_ready) || g < 0) return '0;
    return N'(1) << g;
  endfunction

  always @(posedge clk) begin
    int g;
    bit acc;
    g = exp_grant();
    acc = !rst && g >= 0 && (!m_rv || bus.res_ready);
    if (rst) begin
      m_rv = 0; m_rd = '0; m_rid = 0; m_ptr = 0;
    end else if (acc) begin
      m_rd = shf(bus.req_data[g*DI +: DI], int'(bus.req_amount[g*SB +: SB]), bus.req_dir[g]);
      m_rid = g; m_rv = 1; m_ptr = (g + 1) % N;
    end else if (m_rv && bus.res_ready) begin
      m_rv = 0;
    end
  end

  always @(negedge clk)
    if (check_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
      chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
      chk("res_data", 32'(bus.res_data), 32'(m_rd));
      chk("res_id", 32'(bus.res_id), 32'(m_rid));
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [DI-1:0] d, input int amt, input bit dir);
    bus.req_valid[i] = v;
    bus.req_data[i*DI +: DI] = d;
    bus.req_amount[i*SB +: SB] = SB'(amt);
    bus.req_dir[i] = dir;
  endtask

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_amount = '0; bus.req_dir = '0;
    bus.res_ready = 1'b1;
    step();
    check_en = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_data", 32'(bus.res_data), 0);
    step();
    set_req(1, 1, 8'hFD, 4, 1);
    @(negedge clk);
    chk("lsh_ready", 32'(bus.req_ready), 32'h2);
    step();
    set_req(1, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("lsh_valid", 32'(bus.res_valid), 1);
    chk("lsh_data", 32'(bus.res_data), 32'hFFFFD0);
    chk("lsh_id", 32'(bus.res_id), 1);
    step();
    set_req(2, 1, 8'h80, 3, 0);
    step();
    set_req(2, 1, 8'h7F, 0, 0);
    @(negedge clk);
    chk("rsh_data", 32'(bus.res_data), 32'hFFFFF0);
    chk("rsh_id", 32'(bus.res_id), 2);
    step();
    set_req(2, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("zero_amt", 32'(bus.res_data), 32'h00007F);
    step();
    rst = 1;
    for (int i = 0; i < N; i++) set_req(i, 1, DI'(i + 1), i, 1);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 0);
    step();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_ready", 32'(bus.req_ready), 32'(1 << (k % N)));
      if (k > 0) chk("rr_id", 32'(bus.res_id), 32'((k - 1) % N));
      step();
    end
    rst = 1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_pending", 32'(bus.res_valid), 1);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.res_valid), 0);
    chk("post_rst_data", 32'(bus.res_data), 0);
    chk("post_rst_id", 32'(bus.res_id), 0);
    chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
    step();
    set_req(1, 0, 8'h00, 0, 0);
    set_req(2, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("skip_grant", 32'(bus.req_ready), 32'h8);
    step();
    set_req(0, 0, 8'h00, 0, 0);
    set_req(3, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("withdraw", 32'(bus.req_ready), 0);
    chk("skip_id", 32'(bus.res_id), 3);
    step();
    set_req(1, 1, 8'h05, 2, 1);
    @(negedge clk);
    chk("ptr_hold", 32'(bus.req_ready), 32'h2);
    step();
    set_req(1, 0, 8'h00, 0, 0);
    set_req(0, 1, 8'h11, 1, 1);
    set_req(3, 1, 8'h81, 1, 0);
    bus.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.req_ready), 0);
      chk("bp_valid", 32'(bus.res_valid), 1);
      chk("bp_data", 32'(bus.res_data), 32'h000014);
      chk("bp_id", 32'(bus.res_id), 1);
      step();
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(bus.req_ready), 32'h8);
    step();
    set_req(3, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("bp_next_valid", 32'(bus.res_valid), 1);
    chk("bp_next_id", 32'(bus.res_id), 3);
    chk("bp_next_data", 32'(bus.res_data), 32'hFFFFC0);
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = $urandom_range(0, 63) == 0;
      bus.res_ready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 2) != 0, DI'($urandom), int'($urandom_range(0, SA - 1)), 1'($urandom));
    end
    step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and scheduler that shares one arithmetic shift datapath among NUM_REQ requesters. It accepts at most one shift request per cycle through per-requester valid/ready handshakes and computes the sign-extending left or arithmetic right shift. It returns the result, tagged with the requester index, through a single registered output stage with backpressure. It sits between the processing lanes and the shared shifter, so the lanes never need their own shift hardware.

## Interface
- NUM_REQ, 4: number of requesters, at least 2.
- DATA_WIDTH_IN, 8: signed operand width.
- SHIFT_AMOUNT, 16: maximum shift range.
- SHIFT_BITS, log2(SHIFT_AMOUNT) = 4: width of each amount field (localparam, ceil-log2).
- DATA_WIDTH_OUT, SHIFT_AMOUNT+DATA_WIDTH_IN = 24: result width.
- ID_BITS, log2(NUM_REQ) = 2: width of the requester tag (localparam).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- req_valid  input  NUM_REQ  bit i: requester i presents a request.
- req_ready  output  NUM_REQ  bit i: request i is accepted this cycle; at most one bit is high.
- req_data  input  NUM_REQ*DATA_WIDTH_IN  signed operands, requester i at slice [i*DATA_WIDTH_IN +: DATA_WIDTH_IN].
- req_amount  input  NUM_REQ*SHIFT_BITS  shift amounts, sliced the same way.
- req_dir  input  NUM_REQ  1 = left shift, 0 = arithmetic right shift.
- res_valid  output  1  result register holds an undelivered result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  DATA_WIDTH_OUT  signed shift result.
- res_id  output  ID_BITS  index of the requester that produced res_data.

## Operation
- **Arithmetic**
  - The operand is sign-extended to DATA_WIDTH_OUT, then shifted.
  - Left shift (dir=1) fills with zeros and truncates to DATA_WIDTH_OUT. No overflow is possible, because amount ≤ SHIFT_AMOUNT−1.
  - Right shift (dir=0) replicates the sign bit.
  - Amount 0 returns the sign-extended operand.
- **Accept condition**
  - can_accept = !res_valid || res_ready.
  - The grant is computed combinationally from req_valid, the rotating pointer ptr and can_accept.
  - req_ready[g] = 1 only for the granted g, only when can_accept is 1 and rst is 0.
- **Round-robin**
  - ptr (ID_BITS wide) marks the highest-priority index.
  - The grant goes to the first i with req_valid[i] high, searching ptr, ptr+1, … mod NUM_REQ.
  - On an accept of g: ptr ← (g+1) mod NUM_REQ.
  - With no accept, ptr holds.
- **Output register**
  - On accept: res_data ← shift result of requester g, res_id ← g, res_valid ← 1.
  - Without accept, if res_valid && res_ready: res_valid ← 0. res_data and res_id hold their last values.
  - While res_valid=1 and res_ready=0: res_valid, res_data and res_id are stable and req_ready is all zero.
- **Requester obligations**
  - A requester holds valid, data, amount and dir stable until it sees req_ready.
  - Deasserting valid before acceptance is permitted. The arbiter then simply skips that requester.
- **Reset**
  - While rst=1: req_ready = 0, and no accept occurs.
  - On the next edge: res_valid=0, res_data=0, res_id=0, ptr=0.
  - A result pending when rst rises is discarded.
  - Requests presented during reset are not accepted. They are arbitrated from ptr=0 in the first cycle after rst falls.

## Timing
- Latency is 1 cycle: a request accepted on edge N appears on res_data/res_id with res_valid=1 after edge N.
- Throughput is 1 result per cycle while res_ready=1, because the accept and the drain happen in the same cycle.
- Combinational paths:
  - res_ready → req_ready.
  - req_valid → req_ready.
  - req_data, req_amount and req_dir of the granted requester → shifter → res_data D-input.
- There is no path from any input to res_data, res_id or res_valid. All three are registered.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.

## Test plan
- **Left shift sign extension**
  - Stimulus: requester 1 sends data=0xFD (−3), amount=4, dir=1, with res_ready=1.
  - Required: req_ready=4'b0010, then one cycle later res_valid=1, res_data=0xFFFFD0, res_id=1.
- **Arithmetic right shift**
  - Stimulus: requester 2 sends data=0x80 (−128), amount=3, dir=0.
  - Required: res_data=0xFFFFF0. Also data=0x7F, amount=0, dir=0 gives res_data=0x00007F.
- **Round-robin order**
  - Stimulus: all four req_valid held high with res_ready=1, from reset.
  - Required: accepts in order 0,1,2,3,0,1; res_id follows one cycle later; one result per cycle.
- **Backpressure**
  - Stimulus: a result pending and res_ready=0 for 3 cycles while requesters 0 and 3 are valid.
  - Required: req_ready=0 throughout, with res_data and res_id unchanged. When res_ready rises, the drain and the next accept occur in the same cycle, and res_valid stays 1.
- **Reset mid-operation**
  - Stimulus: assert rst for one cycle with res_valid=1 and ptr=2.
  - Required: after the edge, res_valid=0, res_data=0, res_id=0. The next grant with all requesters valid goes to 0.
- **Skip and withdraw**
  - Stimulus: ptr=1, only requesters 0 and 3 valid.
  - Required: the grant goes to 3, then ptr=0. If requester 0 withdraws valid before its grant, no accept occurs and ptr holds.
